// File: rtl/f32_to_rec_fn_pipe.sv
// Two-stage binary32 -> 33-bit recoded-float converter with valid/ready on both sides.
// Stage 1 splits the operand and finds the subnormal normalisation distance; stage 2 builds the recoded word.
module f32_to_rec_fn_pipe #(
  parameter int TAG_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_bits,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [32:0]      out_bits,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_is_snan,
  output logic             out_is_subnormal
);

  function automatic logic [4:0] clz23(input logic [22:0] f);
    logic [4:0] n;
    n = 5'd22;
    for (int i = 0; i < 23; i++) begin
      if (f[i]) n = 5'(22 - i);
    end
    return n;
  endfunction

  function automatic logic [8:0] rec_exp(input logic [8:0] adj, input logic is_zero,
                                         input logic is_nan);
    // Zero clears the three class bits; NaN sets the lowest of them on top of the Inf code.
    return {(adj[8:6] & ~{3{is_zero}}) | {2'b00, is_nan}, adj[5:0]};
  endfunction

  logic             vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic             en1, en2;

  logic             sign_p1_q, sign_p1_d, zexp_p1_q, zexp_p1_d, zfract_p1_q, zfract_p1_d;
  logic [7:0]       exp_p1_q, exp_p1_d;
  logic [22:0]      fract_p1_q, fract_p1_d;
  logic [4:0]       norm_p1_q, norm_p1_d;
  logic [TAG_W-1:0] tag_p1_q, tag_p1_d;

  logic [32:0]      bits_p2_q, bits_p2_d;
  logic             snan_p2_q, snan_p2_d, sub_p2_q, sub_p2_d;
  logic [TAG_W-1:0] tag_p2_q, tag_p2_d;

  logic [22:0]      sub_fract;
  logic [8:0]       adj;
  logic             is_zero, is_special, is_nan;

  always_comb begin
    en2      = ~vld_p2_q | out_ready;
    en1      = ~vld_p1_q | en2;
    vld_p1_d = en1 ? in_valid : vld_p1_q;
    vld_p2_d = en2 ? vld_p1_q : vld_p2_q;

    // ---- stage 1: split operand, leading-zero count of the fraction ----
    sign_p1_d   = sign_p1_q;
    exp_p1_d    = exp_p1_q;
    fract_p1_d  = fract_p1_q;
    norm_p1_d   = norm_p1_q;
    zexp_p1_d   = zexp_p1_q;
    zfract_p1_d = zfract_p1_q;
    tag_p1_d    = tag_p1_q;
    if (in_valid & en1) begin
      sign_p1_d   = in_bits[31];
      exp_p1_d    = in_bits[30:23];
      fract_p1_d  = in_bits[22:0];
      norm_p1_d   = clz23(in_bits[22:0]);
      zexp_p1_d   = (in_bits[30:23] == 8'd0);
      zfract_p1_d = (in_bits[22:0] == 23'd0);
      tag_p1_d    = in_tag;
    end

    // ---- stage 2: exponent adjust, normalised subnormal fraction, class flags ----
    sub_fract  = (fract_p1_q << norm_p1_q) << 1;
    adj        = (zexp_p1_q ? ({4'd0, norm_p1_q} ^ 9'h1FF) : {1'b0, exp_p1_q})
               + (zexp_p1_q ? 9'd130 : 9'd129);
    is_zero    = zexp_p1_q & zfract_p1_q;
    is_special = (adj[8:7] == 2'b11);
    is_nan     = is_special & ~zfract_p1_q;

    bits_p2_d = bits_p2_q;
    snan_p2_d = snan_p2_q;
    sub_p2_d  = sub_p2_q;
    tag_p2_d  = tag_p2_q;
    if (vld_p1_q & en2) begin
      bits_p2_d = {sign_p1_q, rec_exp(adj, is_zero, is_nan),
                   zexp_p1_q ? sub_fract : fract_p1_q};
      snan_p2_d = is_nan & ~fract_p1_q[22];
      sub_p2_d  = zexp_p1_q & ~zfract_p1_q;
      tag_p2_d  = tag_p1_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  always_ff @(posedge clock) begin
    sign_p1_q   <= sign_p1_d;
    exp_p1_q    <= exp_p1_d;
    fract_p1_q  <= fract_p1_d;
    norm_p1_q   <= norm_p1_d;
    zexp_p1_q   <= zexp_p1_d;
    zfract_p1_q <= zfract_p1_d;
    tag_p1_q    <= tag_p1_d;
    bits_p2_q   <= bits_p2_d;
    snan_p2_q   <= snan_p2_d;
    sub_p2_q    <= sub_p2_d;
    tag_p2_q    <= tag_p2_d;
  end

  // ---- output boundary ----
  assign in_ready         = en1;
  assign out_valid        = vld_p2_q;
  assign out_bits         = bits_p2_q;
  assign out_tag          = tag_p2_q;
  assign out_is_snan      = snan_p2_q;
  assign out_is_subnormal = sub_p2_q;

endmodule

// File: tb/tb_f32_to_rec_fn_pipe.sv
// Directed bench for f32_to_rec_fn_pipe: hand-computed recodings, latency, backpressure and reset.
module tb_f32_to_rec_fn_pipe;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_bits = 32'd0;
  logic [7:0]  in_tag = 8'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [32:0] out_bits;
  logic [7:0]  out_tag;
  logic        out_is_snan;
  logic        out_is_subnormal;

  f32_to_rec_fn_pipe #(.TAG_W(8)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits), .out_tag(out_tag),
    .out_is_snan(out_is_snan), .out_is_subnormal(out_is_subnormal)
  );

  always #5 clock = ~clock;

  // Hand-computed vectors: input, tag, recoded word, sNaN flag, subnormal flag.
  logic [31:0] v_in [14] = '{32'h3F800000, 32'h00000001, 32'h80000000, 32'h7F800000,
                             32'h7FC00000, 32'h7F800001, 32'h00400000, 32'hC0000000,
                             32'h00000000, 32'h7F7FFFFF, 32'h00800000, 32'hFFC00001,
                             32'h007FFFFF, 32'h00000003};
  logic [7:0]  v_tag [14] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                              8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
  logic [32:0] v_out [14] = '{33'h080000000, 33'h035800000, 33'h115800000, 33'h0C0000000,
                              33'h0E0400000, 33'h0E0000001, 33'h040800000, 33'h180800000,
                              33'h015800000, 33'h0BFFFFFFF, 33'h041000000, 33'h1E0400001,
                              33'h040FFFFFE, 33'h036400000};
  logic        v_snan [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        v_sub [14]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  int exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic send(input int i);
    logic acc;
    int   guard;
    acc   = 1'b0;
    guard = 0;
    in_valid = 1'b1;
    in_bits  = v_in[i];
    in_tag   = v_tag[i];
    while (!acc && guard < 200) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      guard++;
    end
    if (acc) exp_q.push_back(i);
    else check("in_ready_timeout", 64'd0, 64'd1);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clock);
      guard++;
    end
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  logic        stall_seen = 1'b0;
  logic [32:0] held_bits;
  logic [7:0]  held_tag;
  int          mon_idx;

  always @(negedge clock) begin
    if (reset) begin
      if (stall_seen) begin
        check("hold_vld", 64'(out_valid), 64'd1);
        check("hold_bits", 64'(out_bits), 64'(held_bits));
        check("hold_tag", 64'(out_tag), 64'(held_tag));
      end
      stall_seen = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'd1, 64'd0);
        end else begin
          mon_idx = exp_q.pop_front();
          check("out_bits", 64'(out_bits), 64'(v_out[mon_idx]));
          check("out_tag", 64'(out_tag), 64'(v_tag[mon_idx]));
          check("out_is_snan", 64'(out_is_snan), 64'(v_snan[mon_idx]));
          check("out_is_subnormal", 64'(out_is_subnormal), 64'(v_sub[mon_idx]));
          n_out++;
        end
      end else if (out_valid) begin
        stall_seen = 1'b1;
        held_bits  = out_bits;
        held_tag   = out_tag;
      end
    end else begin
      stall_seen = 1'b0;
    end
  end

  initial begin
    #1 reset = 1'b0;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;

    // Single element, latency
    send(0);
    @(negedge clock);
    check("lat_cycle1", 64'(out_valid), 64'd0);
    @(negedge clock);
    check("lat_cycle2", 64'(out_valid), 64'd1);
    @(posedge clock);
    #1;
    drain();

    // Back-to-back stream of all vectors
    for (int i = 0; i < 14; i++) send(i);
    drain();

    // Backpressure window on cycles 3..6
    fork
      begin
        for (int i = 0; i < 8; i++) send(i);
      end
      begin
        for (int c = 0; c < 12; c++) begin
          out_ready = !(c >= 3 && c <= 6);
          if (c == 5) begin
            @(negedge clock);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
          end
          @(posedge clock);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Random gaps and random out_ready
    fork
      begin
        for (int i = 0; i < 14; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clock);
            #1;
          end
          send(i);
        end
      end
      begin
        for (int c = 0; c < 60; c++) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clock);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with both stages full
    out_ready = 1'b0;
    send(0);
    send(1);
    #1 reset = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    @(posedge clock);
    #1 reset = 1'b1;
    out_ready = 1'b1;
    send(3);
    @(negedge clock);
    check("post_rst_lat1", 64'(out_valid), 64'd0);
    @(negedge clock);
    check("post_rst_lat2", 64'(out_valid), 64'd1);
    @(posedge clock);
    #1;
    drain();

    repeat (3) @(posedge clock);
    #1;
    check("out_count", 64'(n_out), 64'd38);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
